// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit. It runs one load or store per instruction over a
// req/ack bus and holds the upstream pipeline until the access retires.
module mem_access_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              done,
  output logic              misalign,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  localparam int unsigned LANES = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        lane_q;
  logic [DATA_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [LANES-1:0]  bus_wstrb_q;
  logic [DATA_W-1:0] load_data_q;
  logic              misalign_q;
  logic              bus_err_q;

  logic              op_c;
  logic              reject_c;
  logic              timeout_c;
  logic [DATA_W-1:0] wdata_fmt_c;
  logic [LANES-1:0]  wstrb_fmt_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic [DATA_W-1:0] load_fmt_c;

  // Request decode: illegal (both ops or reserved size) and misaligned are both rejected.
  always_comb begin
    op_c      = mem_read | mem_write;
    reject_c  = (mem_read & mem_write) | (mem_size == 2'b11)
              | ((mem_size == 2'b01) & addr_in[0])
              | ((mem_size == 2'b10) & (addr_in[1:0] != 2'b00));
    timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // Store data is replicated across lanes; strobes select the addressed lanes.
  always_comb begin
    wdata_fmt_c = wdata_in;
    wstrb_fmt_c = '0;
    case (mem_size)
      2'b00: begin
        wdata_fmt_c = {4{wdata_in[7:0]}};
        wstrb_fmt_c = 4'b0001 << addr_in[1:0];
      end
      2'b01: begin
        wdata_fmt_c = {2{wdata_in[15:0]}};
        wstrb_fmt_c = 4'b0011 << addr_in[1:0];
      end
      2'b10: wstrb_fmt_c = 4'b1111;
      default: wstrb_fmt_c = '0;
    endcase
    if (!mem_write) wstrb_fmt_c = '0;
  end

  // Load lane selection and extension, using the fields captured at accept.
  always_comb begin
    case (lane_q)
      2'd0:    byte_c = bus_rdata[7:0];
      2'd1:    byte_c = bus_rdata[15:8];
      2'd2:    byte_c = bus_rdata[23:16];
      default: byte_c = bus_rdata[31:24];
    endcase
    half_c = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'b00:   load_fmt_c = uns_q ? {24'b0, byte_c} : {{24{byte_c[7]}}, byte_c};
      2'b01:   load_fmt_c = uns_q ? {16'b0, half_c} : {{16{half_c[15]}}, half_c};
      default: load_fmt_c = bus_rdata;
    endcase
    if (we_q) load_fmt_c = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (op_c) state_d = reject_c ? S_DONE : S_BUSY;
      S_BUSY: if (bus_ack || timeout_c) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Gating stall with rst keeps it low while reset is held even if an op is presented.
  always_comb begin
    stall   = 1'b0;
    done    = 1'b0;
    bus_req = 1'b0;
    case (state_q)
      S_IDLE: stall = op_c & rst;
      S_BUSY: begin
        stall   = 1'b1;
        bus_req = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Capture at accept; result and error flags land on the transition into DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      load_data_q <= '0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_c) begin
            we_q        <= mem_write;
            size_q      <= mem_size;
            uns_q       <= mem_unsigned;
            lane_q      <= addr_in[1:0];
            bus_addr_q  <= {addr_in[DATA_W-1:2], 2'b00};
            bus_wdata_q <= wdata_fmt_c;
            bus_wstrb_q <= wstrb_fmt_c;
            cnt_q       <= '0;
            load_data_q <= '0;
            misalign_q  <= reject_c;
            bus_err_q   <= 1'b0;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus_ack)        load_data_q <= load_fmt_c;
          else if (timeout_c) bus_err_q   <= 1'b1;
        end
        S_DONE: begin
          misalign_q <= 1'b0;
          bus_err_q  <= 1'b0;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign load_data = load_data_q;
  assign misalign  = misalign_q;
  assign bus_err   = bus_err_q;
  assign bus_we    = we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage data-memory access unit. It consumes the address, store data and memory control fields held by the EX/MEM pipeline register. It performs one load or store per instruction over a req/ack data bus, freezing the upstream pipeline with `stall` until the access completes. Load results are returned byte/half/word aligned and sign- or zero-extended, and the unit flags misaligned, illegal and timed-out accesses.

Parameters:
DATA_W, 32, data and address width (bus is one 32-bit word; byte lanes fixed at 4).
TIMEOUT, 255, BUSY cycles without ack before a bus error is declared (1..65535).
CNT_W, 16, width of the timeout counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
addr_in  in  DATA_W  effective address (ALU result from EX/MEM).
wdata_in  in  DATA_W  store source (rs2 value from EX/MEM).
mem_read  in  1  load request.
mem_write  in  1  store request.
mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
mem_unsigned  in  1  1 = zero-extend load, 0 = sign-extend.
stall  out  1  hold EX/MEM and earlier stages this cycle.
load_data  out  DATA_W  formatted load result; valid when `done`.
done  out  1  one-cycle pulse: access finished this cycle.
misalign  out  1  with `done`: misaligned or illegal access, no bus traffic.
bus_err  out  1  with `done`: timeout, no ack.
bus_req  out  1  bus request.
bus_we  out  1  1 = write.
bus_addr  out  DATA_W  word address, bits [1:0] = 00.
bus_wdata  out  DATA_W  lane-replicated store data.
bus_wstrb  out  4  byte enables; 0000 for reads.
bus_rdata  in  DATA_W  read word, sampled when bus_ack=1.
bus_ack  in  1  access complete.

Behaviour:
- Reset (rst=0, async): state IDLE; counter 0; all registered outputs 0.
  - stall=0, done=0, misalign=0, bus_err=0, load_data=0.
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0.
  - bus_req drops in the same cycle reset asserts.
  - A reset mid-access abandons it; no done pulse.
- States: IDLE, BUSY, DONE.
- IDLE:
  - op = mem_read|mem_write. If op=0: stall=0, stay IDLE.
  - If op=1: stall=1 (combinational). Capture addr, data, size, unsigned and we=mem_write.
  - Illegal if mem_read&mem_write, or size=11.
  - Misaligned if half with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal or misaligned: go DONE with misalign=1, load_data=0, no bus_req.
  - Otherwise go BUSY and clear the counter.
- BUSY:
  - bus_req=1; bus_we, bus_addr, bus_wdata, bus_wstrb stable from the capture. stall=1.
  - Counter increments each cycle.
  - On bus_ack: latch formatted load_data (0 for stores), go DONE.
  - Else if counter == TIMEOUT-1: go DONE with bus_err=1, load_data=0.
  - If ack arrives on the timeout cycle, ack wins.
- DONE (exactly one cycle):
  - done=1, stall=0; the pipeline advances at the end of this cycle.
  - Inputs still show the same op during DONE; they are not re-accepted.
  - Next state is IDLE.
- bus_ack outside BUSY is ignored. bus_req never asserts in IDLE or DONE.
- Minimum latency: accept cycle T0 (stall), T1 BUSY with ack, T2 DONE. That is 2 stall cycles; each wait cycle adds 1.
- Store formatting:
  - byte: wdata = {4{d[7:0]}}, wstrb = 0001 << addr[1:0].
  - half: wdata = {2{d[15:0]}}, wstrb = 0011 << addr[1:0].
  - word: wdata = d, wstrb = 1111.
- Load formatting:
  - byte: lane bus_rdata[8*a+7 : 8*a], a = addr[1:0].
  - half: lane bus_rdata[16*h+15 : 16*h], h = addr[1].
  - Extend per mem_unsigned. word: unchanged.
- misalign and bus_err are asserted only together with done.

Test Plan:
- Word load @0x100, ack in the first BUSY cycle, rdata=0xDEADBEEF -> stall high for 2 cycles; done with load_data=0xDEADBEEF; bus_addr=0x100, wstrb=0000.
- Signed byte load @0x103, rdata=0x80112233 -> load_data=0xFFFFFF80. Unsigned byte load -> 0x00000080. Unsigned half load @0x102 -> 0x00008011.
- Half store @0x202, data=0x0000ABCD, ack after 3 wait cycles -> bus_wdata=0xABCDABCD, wstrb=1100, bus_addr=0x200; stall for 5 cycles, then a done pulse.
- Word load @0x101, then mem_read=mem_write=1 -> each gives one stall cycle, done with misalign=1, bus_req never asserts.
- TIMEOUT=4, no ack -> bus_req held 4 cycles, then done with bus_err=1 and load_data=0. A second run with ack on the 4th cycle -> normal done, bus_err=0.
- rst=0 mid-BUSY -> bus_req=0 immediately, no done pulse; after release with op=0 -> stall=0, state IDLE.
